// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single-outstanding-request
// memory port. A four-state FSM issues a request at PC, waits for the
// response and presents it to the IF/ID register. A redirect from execute
// that arrives while a request is in flight makes the FSM drop the stale
// response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    READY   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic [31:0]  buf_q;
  logic [31:0]  buf_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  target_aligned;

  // Redirect targets are word aligned; PC+4 wraps naturally at 2^32.
  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = {PCTargetE[31:2], 2'b00};

  // State, PC and instruction buffer registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic: redirects always win, responses for abandoned requests are dropped.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    unique case (state_q)
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (PCSrcE) begin
          pc_d    = target_aligned;
          state_d = imem_rvalid ? ISSUE : DISCARD;
        end else if (imem_rvalid) begin
          buf_d   = imem_rdata;
          state_d = READY;
        end
      end
      READY: begin
        if (PCSrcE) begin
          pc_d    = target_aligned;
          state_d = ISSUE;
        end else if (!StallF) begin
          pc_d    = pc_plus4;
          state_d = ISSUE;
        end
      end
      DISCARD: begin
        if (PCSrcE) begin
          pc_d = target_aligned;
        end
        if (imem_rvalid) begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  // Output decode: request only in ISSUE outside reset, fetched word only in READY.
  always_comb begin
    imem_req   = (state_q == ISSUE) && !reset;
    imem_addr  = {pc_q[31:2], 2'b00};
    PCF        = pc_q;
    PCplus4F   = pc_plus4;
    InstrF     = NOP_INSTR;
    fetch_busy = 1'b1;
    if (state_q == READY) begin
      InstrF     = buf_q;
      fetch_busy = 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble driven on InstrF when no fetched instruction is available.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-005 SHALL have port StallF, input, 1 bit: 1 = hold the current instruction and PC.
REQ-006 SHALL have port PCSrcE, input, 1 bit: redirect request from the execute stage.
REQ-007 SHALL have port PCTargetE, input, 32 bits: redirect address.
REQ-008 SHALL have port imem_req, output, 1 bit: one-cycle fetch request pulse.
REQ-009 SHALL have port imem_addr, output, 32 bits: fetch address, valid while imem_req=1.
REQ-010 SHALL have port imem_rvalid, input, 1 bit: response strobe for the single outstanding request.
REQ-011 SHALL have port imem_rdata, input, 32 bits: instruction word, valid while imem_rvalid=1.
REQ-012 SHALL have ports InstrF, PCF and PCplus4F, all outputs, 32 bits each, driving the IF/ID pipeline register.
REQ-013 SHALL have port fetch_busy, output, 1 bit: 1 = InstrF carries NOP_INSTR, not a fetched word.

Function
REQ-014 SHALL implement the states ISSUE, WAIT, READY and DISCARD, plus a 32-bit PC register and a 32-bit instruction buffer.
REQ-015 SHALL, in ISSUE, drive imem_req=1 and imem_addr=PC, then move unconditionally to WAIT; imem_req SHALL be 0 in every other state.
REQ-016 SHALL, in WAIT with imem_rvalid=1 and PCSrcE=0, capture imem_rdata into the buffer and move to READY.
REQ-017 SHALL, in WAIT with PCSrcE=1 and imem_rvalid=0, load PC from PCTargetE and move to DISCARD.
REQ-018 SHALL, in WAIT with PCSrcE=1 and imem_rvalid=1 in the same cycle, drop the response, load PC from PCTargetE and move to ISSUE.
REQ-019 SHALL, in READY with PCSrcE=1, load PC from PCTargetE and move to ISSUE, regardless of StallF; PCSrcE SHALL take priority over StallF.
REQ-020 SHALL, in READY with PCSrcE=0 and StallF=0, set PC to PC+4 and move to ISSUE; the IF/ID register consumes the instruction on this same edge.
REQ-021 SHALL, in READY with PCSrcE=0 and StallF=1, hold PC, the buffer and the state.
REQ-022 SHALL, in DISCARD with imem_rvalid=1, drop the response and move to ISSUE; PCSrcE=1 in that cycle SHALL still update PC.
REQ-023 SHALL, in DISCARD with imem_rvalid=0 and PCSrcE=1, update PC and remain in DISCARD.
REQ-024 SHALL ignore imem_rvalid in ISSUE and READY; this is a protocol violation with no state effect.
REQ-025 SHALL drive PCF=PC and PCplus4F=PC+4 in every state.
REQ-026 SHALL drive InstrF=buffer and fetch_busy=0 in READY, and InstrF=NOP_INSTR and fetch_busy=1 in all other states.
REQ-027 SHALL compute PC+4 modulo 2^32, so that 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-028 SHALL load PC from PCTargetE with bits [1:0] forced to 0, and SHALL keep imem_addr[1:0] = 2'b00 at all times.
REQ-029 SHALL keep at most one memory request outstanding, and SHALL issue a new request no earlier than the cycle after the prior response or discard.

Reset
REQ-030 SHALL, while reset=1, immediately force state=ISSUE, PC=RESET_PC, buffer=NOP_INSTR and imem_req=0, independent of clk.
REQ-031 SHALL, while reset=1, drive InstrF=NOP_INSTR, PCF=RESET_PC, PCplus4F=RESET_PC+4 and fetch_busy=1.
REQ-032 SHALL assert its first imem_req, with imem_addr=RESET_PC, in the first clk cycle after reset deasserts.
REQ-033 SHALL, if reset asserts mid-WAIT, ignore any imem_rvalid for the abandoned request that arrives during reset; a response arriving after reset release is also treated as stale in ISSUE and ignored.

Verification
REQ-034 SHALL cover 1-cycle memory latency with StallF=0 from reset: imem_addr sequence 0x0, 0x4, 0x8, one request every 3 cycles, InstrF equal to the returned words in READY, and NOP with fetch_busy=1 otherwise.
REQ-035 SHALL cover StallF=1 held for 4 cycles in READY with InstrF=0x00A00093: InstrF, PCF and PCplus4F stable and no imem_req; after release, PC=PCF+4.
REQ-036 SHALL cover PCSrcE=1 with PCTargetE=0x0000_0103 during WAIT and rvalid 3 cycles later: the response is dropped, the next imem_addr is 0x0000_0100, and InstrF never shows the dropped word.
REQ-037 SHALL cover PCSrcE=1 and imem_rvalid=1 in the same WAIT cycle: the data is discarded and the next cycle issues imem_req at the target.
REQ-038 SHALL cover RESET_PC=0xFFFF_FFFC: the first fetch is at 0xFFFF_FFFC, PCplus4F=0x0000_0000, and the second fetch is at 0x0.
REQ-039 SHALL cover asynchronous reset asserted mid-WAIT, between clock edges: outputs go to reset values without a clk edge, and after release the first request is at RESET_PC.
